// File: rtl/rom_uart_loader_pkg.sv
// ============================================================================
// rom_uart_loader_pkg : shared constants, state encodings and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package rom_uart_loader_pkg;

   localparam int           MEM           = 32;
   localparam int           MEM_ADDR      = 32;
   localparam logic         WRITE_ENABLE  = 1'b1;
   localparam logic         WRITE_DISABLE = 1'b0;
   localparam logic [7:0]   SYNC_BYTE     = 8'hA5;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_DONE   = 3'd4
   } load_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Byte address of a 32-bit ROM word.
   function automatic logic [MEM_ADDR-1:0] word_addr(input logic [15:0] idx);
      return {{(MEM_ADDR-18){1'b0}}, idx, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rom_uart_loader_uart_rx.sv
// ============================================================================
// uart_rx : 8N1 receiver with input synchronizer and glitch-rejecting start
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import rom_uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_ferr_o
);

   localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam int HALF = CLKS_PER_BIT / 2;

   rx_state_e       state_q, state_d;
   logic [1:0]      sync_q;
   logic            prev_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            rx_s;

   assign rx_s      = sync_q[1];
   assign rx_data_o = shift_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         prev_q  <= rx_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rx_valid_o = 1'b0;
      rx_ferr_o  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (prev_q && !rx_s) state_d = RX_START;
         end
         RX_START: begin
            // Mid-bit recheck; a line back high means the edge was a glitch.
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d      = '0;
               state_d    = RX_IDLE;
               rx_valid_o = rx_s;
               rx_ferr_o  = !rx_s;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rom_uart_loader.sv
// ============================================================================
// rom_uart_loader : boot loader streaming a UART program image into ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module rom_uart_loader
   import rom_uart_loader_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200,
   parameter int DEPTH    = 4096
) (
   input  logic                clk_100MHz,
   input  logic                rst,
   input  logic                uart_rx_i,
   output logic                hold_o,
   output logic                rom_w_ena_o,
   output logic [MEM_ADDR-1:0] rom_w_addr_o,
   output logic [MEM-1:0]      rom_w_data_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk_i      (clk_100MHz),
      .rst_i      (rst),
      .rx_i       (uart_rx_i),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .rx_ferr_o  (rx_ferr)
   );

   load_state_e         state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         widx_q, widx_d;
   logic [1:0]          bsel_q, bsel_d;
   logic [23:0]         buf_q, buf_d;
   logic                last_q, last_d;
   logic                ena_q, ena_d;
   logic [MEM_ADDR-1:0] addr_q, addr_d;
   logic [MEM-1:0]      data_q, data_d;
   logic                err_q, err_d;
   logic [15:0]         w_len;

   assign w_len        = {rx_data, len_q[7:0]};
   assign hold_o       = (state_q != ST_DONE);
   assign done_o       = (state_q == ST_DONE);
   assign err_o        = err_q;
   assign rom_w_ena_o  = ena_q;
   assign rom_w_addr_o = addr_q;
   assign rom_w_data_o = data_q;

   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         state_q <= ST_SYNC;
         len_q   <= '0;
         widx_q  <= '0;
         bsel_q  <= '0;
         buf_q   <= '0;
         last_q  <= 1'b0;
         ena_q   <= WRITE_DISABLE;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         bsel_q  <= bsel_d;
         buf_q   <= buf_d;
         last_q  <= last_d;
         ena_q   <= ena_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      bsel_d  = bsel_q;
      buf_d   = buf_q;
      last_d  = last_q;
      ena_d   = WRITE_DISABLE;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;

      case (state_q)
         ST_SYNC: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               err_d   = 1'b0;
               state_d = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (rx_valid) begin
               len_d[7:0] = rx_data;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_valid) begin
               len_d  = w_len;
               widx_d = '0;
               bsel_d = '0;
               last_d = 1'b0;
               if (w_len == 16'd0) begin
                  state_d = ST_DONE;
               end else if ({16'd0, w_len} > 32'(DEPTH)) begin
                  err_d   = 1'b1;
                  state_d = ST_SYNC;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // The final write pulse gets its own cycle before DONE.
            if (last_q) begin
               last_d  = 1'b0;
               state_d = ST_DONE;
            end else if (rx_valid) begin
               bsel_d = bsel_q + 2'd1;
               case (bsel_q)
                  2'd0: buf_d[7:0]   = rx_data;
                  2'd1: buf_d[15:8]  = rx_data;
                  2'd2: buf_d[23:16] = rx_data;
                  default: begin
                     ena_d  = WRITE_ENABLE;
                     addr_d = word_addr(widx_q);
                     data_d = {rx_data, buf_q};
                     widx_d = widx_q + 16'd1;
                     if (widx_q == len_q - 16'd1) last_d = 1'b1;
                  end
               endcase
            end
         end
         ST_DONE: ;
         default: state_d = ST_SYNC;
      endcase

      if (rx_ferr && state_q != ST_DONE) begin
         err_d   = 1'b1;
         state_d = ST_SYNC;
         widx_d  = '0;
         bsel_d  = '0;
         last_d  = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rom_uart_loader.sv
// ============================================================================
// tb_rom_uart_loader : scoreboard bench for the UART ROM loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rom_uart_loader;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 62_500;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_line = 1'b1;
   logic        hold_o, rom_w_ena_o, done_o, err_o;
   logic [31:0] rom_w_addr_o, rom_w_data_o;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_count = 0;
   int          last_wr_cyc = -100;
   int          done_rise_cyc = -1;
   logic        done_prev = 1'b0;
   logic [63:0] exp_q[$];

   rom_uart_loader #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DEPTH    (4096)
   ) dut (
      .clk_100MHz   (clk),
      .rst          (rst),
      .uart_rx_i    (rx_line),
      .hold_o       (hold_o),
      .rom_w_ena_o  (rom_w_ena_o),
      .rom_w_addr_o (rom_w_addr_o),
      .rom_w_data_o (rom_w_data_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Write monitor: every pulse is matched against the expected queue.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rom_w_ena_o) begin
         wr_count++;
         last_wr_cyc = cyc;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write got addr=%h data=%h, none expected", rom_w_addr_o, rom_w_data_o);
         end else begin
            e = exp_q.pop_front();
            if ({rom_w_addr_o, rom_w_data_o} !== e) begin
               n_err++;
               $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                        rom_w_addr_o, rom_w_data_o, e[63:32], e[31:0]);
            end
         end
         n_vec++;
         if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_with_write got done=%b, expected 0 during write", done_o);
         end
      end
      if (done_o === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
      done_prev = done_o;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      rx_line = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
   endtask

   task automatic send_bit(input logic v);
      rx_line = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(!bad_stop);
      rx_line = 1'b1;
   endtask

   task automatic send_bytes(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      int k = 0;
      while (done_o !== 1'b1 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (done_o !== 1'b1) begin
         n_err++;
         $display("FAIL %s_timeout got done=%b after %0d cycles, expected 1", name, done_o, k);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      int w0;
      do_reset();
      w0 = wr_count;
      idle(1000);
      n_vec++;
      if (hold_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || rom_w_ena_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl got hold=%b done=%b err=%b ena=%b, expected 1 0 0 0",
                  hold_o, done_o, err_o, rom_w_ena_o);
      end
      n_vec++;
      if (rom_w_addr_o !== 32'h0 || rom_w_data_o !== 32'h0 || wr_count != w0) begin
         n_err++;
         $display("FAIL reset_port got addr=%h data=%h writes=%0d, expected 0 0 0",
                  rom_w_addr_o, rom_w_data_o, wr_count - w0);
      end
   endtask

   task automatic test_two_word();
      int w0;
      do_reset();
      w0 = wr_count;
      exp_q.push_back({32'h0, 32'h0000_0013});
      exp_q.push_back({32'h4, 32'h0001_02B7});
      send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h01, 8'h00});
      wait_done("two_word", 50);
      idle(4);
      n_vec++;
      if (wr_count - w0 != 2 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL two_word_count got %0d writes (%0d pending), expected 2 (0)",
                  wr_count - w0, exp_q.size());
         exp_q.delete();
      end
      check_bit("two_word_hold", hold_o, 1'b0);
      n_vec++;
      if (done_rise_cyc - last_wr_cyc != 1) begin
         n_err++;
         $display("FAIL done_latency got %0d cycles after last write, expected 1",
                  done_rise_cyc - last_wr_cyc);
      end
      // Line is ignored once done.
      send_bytes('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
      n_vec++;
      if (wr_count - w0 != 2 || done_o !== 1'b1) begin
         n_err++;
         $display("FAIL done_ignore got %0d writes done=%b, expected 2 writes done=1",
                  wr_count - w0, done_o);
      end
   endtask

   task automatic test_zero_len();
      int w0;
      do_reset();
      w0 = wr_count;
      send_bytes('{8'hA5, 8'h00, 8'h00});
      wait_done("zero_len", 50);
      idle(4);
      n_vec++;
      if (wr_count != w0 || hold_o !== 1'b0) begin
         n_err++;
         $display("FAIL zero_len got %0d writes hold=%b, expected 0 writes hold=0",
                  wr_count - w0, hold_o);
      end
   endtask

   task automatic test_len_overflow();
      do_reset();
      send_bytes('{8'hA5, 8'h01, 8'h10});
      idle(4);
      check_bit("ovf_err", err_o, 1'b1);
      check_bit("ovf_hold", hold_o, 1'b1);
      check_bit("ovf_done", done_o, 1'b0);
      exp_q.push_back({32'h0, 32'hDEAD_BEEF});
      send_byte(8'hA5, 1'b0);
      idle(2);
      check_bit("ovf_err_clear", err_o, 1'b0);
      send_bytes('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
      wait_done("ovf_retry", 50);
      check_bit("ovf_retry_err", err_o, 1'b0);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ovf_retry_pending got %0d writes pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_frame_error();
      int w0;
      do_reset();
      w0 = wr_count;
      send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
      send_byte(8'h33, 1'b1);
      idle(2 * CPB);
      send_byte(8'h44, 1'b0);
      idle(4);
      n_vec++;
      if (wr_count != w0) begin
         n_err++;
         $display("FAIL ferr_write got %0d writes, expected 0", wr_count - w0);
      end
      check_bit("ferr_err", err_o, 1'b1);
      check_bit("ferr_hold", hold_o, 1'b1);
      exp_q.push_back({32'h0, 32'h4433_2211});
      send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
      wait_done("ferr_retry", 50);
      check_bit("ferr_retry_err", err_o, 1'b0);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ferr_retry_pending got %0d writes pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send_bytes('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03});
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (hold_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || rom_w_ena_o !== 1'b0 ||
          rom_w_addr_o !== 32'h0 || rom_w_data_o !== 32'h0) begin
         n_err++;
         $display("FAIL midframe_reset got hold=%b done=%b err=%b ena=%b addr=%h data=%h, expected reset values",
                  hold_o, done_o, err_o, rom_w_ena_o, rom_w_addr_o, rom_w_data_o);
      end
      idle(2);
      rst = 1'b0;
      idle(2);
      exp_q.push_back({32'h0, 32'hCAFE_F00D});
      exp_q.push_back({32'h4, 32'h1234_5678});
      send_bytes('{8'hA5, 8'h02, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h78, 8'h56, 8'h34, 8'h12});
      wait_done("midframe_reload", 50);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL midframe_pending got %0d writes pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_zero_len();
      test_len_overflow();
      test_frame_error();
      test_reset_midframe();
      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rom_uart_loader.md
# rom_uart_loader

Boot-time instruction loader sitting between an external UART pin and the ROM write port of the SoC; the ROM write port is otherwise tied off.
- Receives a framed program image over UART, assembles little-endian 32-bit words and writes them into ROM at consecutive word addresses.
- Holds the pipeline core via `hold_o` until the image is complete.
- After a good frame, releases hold and ignores the line until reset.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (868 at defaults).
- `DEPTH`, 4096: ROM capacity in 32-bit words.

Ports:
- `clk_100MHz`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `uart_rx_i`, in, 1: serial line, idle high, 8N1, LSB first. Asynchronous to the clock.
- `hold_o`, out, 1: stall request to the core. High while loading.
- `rom_w_ena_o`, out, 1: ROM write strike (`WRITE_ENABLE` level), one-cycle pulse.
- `rom_w_addr_o`, out, 32 (`MEM_ADDR`): byte address, `4*word_index`.
- `rom_w_data_o`, out, 32 (`MEM`): assembled word.
- `done_o`, out, 1: image loaded. Sticky until reset.
- `err_o`, out, 1: frame error seen. Sticky until the next valid sync byte.

## Operation
- Frame format: sync byte `0xA5`, `LEN_LO`, `LEN_HI` (16-bit word count N), then 4*N data bytes. Each word is sent LSB byte first.
- FSM states: `SYNC`, `LEN_LO`, `LEN_HI`, `DATA`, `DONE`.
  - `SYNC`: bytes other than `0xA5` are discarded. On `0xA5`, clear `err_o` and go to `LEN_LO`.
  - `LEN_LO` → `LEN_HI` on the next byte.
  - `LEN_HI` → `DATA` on the next byte, with the following exceptions:
    - N==0: go straight to `DONE`.
    - N>DEPTH: set `err_o` and go to `SYNC`.
  - `DATA`:
    - Byte counter `bsel` (2 bits) shifts bytes into a 32-bit holding register at lane `bsel`.
    - On `bsel`==3: pulse a write with address `{word_idx,2'b00}`, then increment `word_idx`.
    - After word N-1 is written, go to `DONE`.
  - `DONE`: `hold_o`=0, `done_o`=1, `uart_rx_i` ignored. This state is terminal.
- Framing error (stop bit sampled 0) in any non-`DONE` state:
  - Byte dropped, `err_o`=1, FSM to `SYNC`, `word_idx`/`bsel` cleared.
  - Words already written stay in ROM.
  - `hold_o` stays 1.
- `hold_o` is 1 in every state except `DONE`.
- `word_idx` is 16 bits; `rom_w_addr_o` is zero-extended to 32 bits.

## Timing
- Reset values:
  - `hold_o`=1.
  - `rom_w_ena_o`=0, `rom_w_addr_o`=0, `rom_w_data_o`=0.
  - `done_o`=0, `err_o`=0.
  - FSM=`SYNC`. Receiver idle.
- Reset asserted mid-frame aborts the frame in the same edge. Any write pulse in flight is not issued.
- Input path: `uart_rx_i` passes through a 2-flop synchronizer, so detection latency is 2 cycles.
- Receiver:
  - Start bit is detected on a falling edge and re-checked at `CLKS_PER_BIT/2`. If it has returned high, the start is rejected as a glitch and the receiver goes back to idle.
  - Data bits are sampled every `CLKS_PER_BIT` after that point. The stop bit is sampled at 9.5 bit times.
  - Byte strobe `rx_valid` is a one-cycle pulse in the stop-sample cycle.
- Write pulse: `rom_w_ena_o` asserts in the cycle after the `rx_valid` of the 4th byte. Address and data are valid in that same cycle and hold their values until the next write.
- Done timing: `hold_o` falls and `done_o` rises on the cycle after the final write pulse, never concurrently with it.
- Back-to-back bytes with no idle time between stop and start must be accepted.

## Structure
- Shared package/`define.v` gets:
  - `SYNC_BYTE` (8'hA5).
  - The state encodings.
  - Existing `MEM`, `MEM_ADDR`, `WRITE_ENABLE`, `WRITE_DISABLE` (reused).
- Sub-module `uart_rx`, parameterised by `CLKS_PER_BIT`:
  - Contains the synchronizer, bit-timer counter and shift register.
  - Outputs `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
- The frame FSM, byte assembly and ROM port live in `rom_uart_loader`.
- SoC integration:
  - Route the ROM `w_*` ports to this block.
  - OR `hold_o` with the external `hold`.

## Test plan
- Reset, line idle 1 ms → `hold_o`=1, no `rom_w_ena_o` pulses, `done_o`=0.
- Send `A5 02 00 13 00 00 00 B7 02 01 00` →
  - Write 0x00000013 at address 0x0.
  - Write 0x000102B7 at address 0x4.
  - Exactly 2 pulses. `done_o`=1 and `hold_o`=0 one cycle after the 2nd pulse.
- Send `A5 00 00` → no writes, `done_o`=1.
- Send `A5 01 10` (N=4097 > DEPTH) → `err_o`=1, FSM back to `SYNC`, `hold_o`=1. Then a valid 1-word frame → `err_o` clears, the word is written at 0x0.
- Corrupt the stop bit of the 3rd data byte of a 1-word frame → no write, `err_o`=1. A retransmitted frame succeeds.
- Assert `rst` after 6 bytes of a 2-word frame → all outputs at reset values. A fresh full frame loads correctly from address 0x0.
